// File: rtl/tri_sched.sv
// Triangle scheduler: runs one object pass per frame_start and buffers source triangles in a small FIFO for the rasterizer.
// Latency: a triangle written into an empty FIFO is presented on tri_out on the cycle after the write edge.
// Backpressure: valid/ready on the output side; fetch_en_out throttles the source and keeps two slots free for in-flight triangles.
module tri_sched #(
  parameter int DEPTH = 4,
  parameter int TRI_W = 384
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             frame_start_in,
  output logic             fetch_start_out,
  output logic             fetch_en_out,
  input  logic [TRI_W-1:0] tri_in,
  input  logic             tri_valid_in,
  input  logic             obj_done_in,
  output logic [TRI_W-1:0] tri_out,
  output logic             tri_valid_out,
  input  logic             tri_ready_in,
  output logic             frame_done_out,
  output logic             busy_out,
  output logic             overrun_out,
  output logic             overflow_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_SLACK = (AW+1)'(DEPTH - 3);

  typedef enum logic [2:0] {IDLE, START, FETCH, DRAIN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [TRI_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             full;
  logic             rd_en;
  logic             wr_req;
  logic             wr_en;
  logic             drop;

  assign full          = (count == CNT_FULL);
  assign tri_valid_out = (count != '0);
  assign rd_en         = tri_valid_out && tri_ready_in;
  // The source is trusted in every active state, including the obj_done cycle and DRAIN.
  assign wr_req        = tri_valid_in && (state != IDLE);
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en         = wr_req && (!full || rd_en);
  assign drop          = wr_req && full && !rd_en;
  // Gate the head with valid so an empty or reset FIFO shows zero rather than stale storage.
  assign tri_out       = tri_valid_out ? mem[rd_ptr] : '0;

  // Occupancy after this edge, used both for the count register and the fetch throttle.
  always_comb begin
    count_nxt = count;
    case ({wr_en, rd_en})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Pass sequencing; DRAIN waits for an empty FIFO with no write landing in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start_in) state_nxt = START;
      START:   state_nxt = FETCH;
      FETCH:   if (obj_done_in) state_nxt = DRAIN;
      DRAIN:   if (!tri_valid_out && !wr_en) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with all control outputs registered off the next state.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= IDLE;
      fetch_start_out <= 1'b0;
      fetch_en_out    <= 1'b0;
      frame_done_out  <= 1'b0;
      busy_out        <= 1'b0;
      overrun_out     <= 1'b0;
      overflow_out    <= 1'b0;
    end else begin
      state           <= state_nxt;
      fetch_start_out <= (state_nxt == START);
      fetch_en_out    <= (state_nxt == FETCH) && (count_nxt <= CNT_SLACK);
      frame_done_out  <= (state_nxt == DONE);
      busy_out        <= (state_nxt != IDLE);
      if (frame_start_in && (state != IDLE)) overrun_out <= 1'b1;
      if (drop) overflow_out <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
    end
  end

  // Triangle storage; contents need no reset because the count qualifies them.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr] <= tri_in;
  end

endmodule

// File: tb/tb_tri_sched.sv
// Bench for tri_sched: random and directed passes against a queue-based reference model.
// Model updates on each rising edge from the inputs; outputs are compared on the falling edge.
// Source and rasterizer behaviour are driven 2 time units after each rising edge.
module tb_tri_sched;
  localparam int DEPTH = 4;
  localparam int TRI_W = 384;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             frame_start = 1'b0;
  logic             fetch_start_out;
  logic             fetch_en_out;
  logic [TRI_W-1:0] tri_in = '0;
  logic             tri_valid = 1'b0;
  logic             obj_done = 1'b0;
  logic [TRI_W-1:0] tri_out;
  logic             tri_valid_out;
  logic             tri_ready = 1'b0;
  logic             frame_done_out;
  logic             busy_out;
  logic             overrun_out;
  logic             overflow_out;

  int n_chk = 0;
  int n_fail = 0;
  int fd_cnt = 0;

  tri_sched #(.DEPTH(DEPTH), .TRI_W(TRI_W)) dut (
    .clk_in(clk), .rst_in(rst), .frame_start_in(frame_start),
    .fetch_start_out(fetch_start_out), .fetch_en_out(fetch_en_out),
    .tri_in(tri_in), .tri_valid_in(tri_valid), .obj_done_in(obj_done),
    .tri_out(tri_out), .tri_valid_out(tri_valid_out), .tri_ready_in(tri_ready),
    .frame_done_out(frame_done_out), .busy_out(busy_out),
    .overrun_out(overrun_out), .overflow_out(overflow_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [TRI_W-1:0] act, input logic [TRI_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pass phase (0 idle, 1 start, 2 fetch, 3 drain, 4 done) plus a triangle queue.
  int               ph = 0;
  logic [TRI_W-1:0] q[$];
  bit               m_fs, m_fe, m_fd, m_busy, m_ovr, m_ovf;
  int               m_sz, m_nph;
  bit               m_rd, m_wr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0; q.delete();
      m_fs = 0; m_fe = 0; m_fd = 0; m_busy = 0; m_ovr = 0; m_ovf = 0;
    end else begin
      m_sz = q.size();
      m_rd = (m_sz > 0) && tri_ready;
      m_wr = tri_valid && (ph != 0);
      if (frame_start && ph != 0) m_ovr = 1;
      if (m_rd) void'(q.pop_front());
      if (m_wr) begin
        if (m_sz < DEPTH || m_rd) q.push_back(tri_in);
        else m_ovf = 1;
      end
      m_nph = ph;
      case (ph)
        0: if (frame_start) m_nph = 1;
        1: m_nph = 2;
        2: if (obj_done) m_nph = 3;
        3: if (m_sz == 0 && !m_wr) m_nph = 4;
        default: m_nph = 0;
      endcase
      ph = m_nph;
      m_fs = (ph == 1);
      m_fd = (ph == 4);
      m_busy = (ph != 0);
      m_fe = (ph == 2) && (q.size() <= DEPTH - 3);
    end
  end

  // Triangles actually handed to the rasterizer, in order.
  logic [TRI_W-1:0] got[$];
  always @(posedge clk) begin
    if (!rst && tri_valid_out && tri_ready) got.push_back(tri_out);
  end

  // Single compare point against the model, away from the active edge.
  always @(negedge clk) begin
    if (frame_done_out) fd_cnt++;
    chk("busy", busy_out, m_busy);
    chk("fetch_start", fetch_start_out, m_fs);
    chk("fetch_en", fetch_en_out, m_fe);
    chk("frame_done", frame_done_out, m_fd);
    chk("overrun", overrun_out, m_ovr);
    chk("overflow", overflow_out, m_ovf);
    chk("tri_valid", tri_valid_out, q.size() != 0);
    chk("count", dut.count, q.size());
    if (q.size() != 0) chk("tri_out", tri_out, q[0]);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [TRI_W-1:0] rtri();
    logic [TRI_W-1:0] t;
    for (int i = 0; i < TRI_W / 32; i++) t[i*32 +: 32] = $urandom;
    return t;
  endfunction

  function automatic logic pick(input int rmode, input int cyc);
    if (rmode == 0) return 1'b1;
    if (rmode == 1) return $urandom_range(0, 3) != 0;
    return cyc >= 10;
  endfunction

  task automatic wait_idle(input int rmode);
    int cyc = 0;
    while (busy_out && cyc < 300) begin
      tri_ready = pick(rmode, cyc + 10);
      tick();
      cyc++;
    end
    if (busy_out) chk("idle_timeout", 1, 0);
    tri_ready = 1'b0;
  endtask

  logic [TRI_W-1:0] exp_q[$];

  task automatic run_pass(input int n, input int rmode, input bit done_with_last, input bit ovr_pulse);
    int sent = 0;
    int cyc = 0;
    exp_q.delete(); got.delete(); fd_cnt = 0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("fetch_start_after_frame_start", fetch_start_out, 1);
    tick();
    while (sent < n && cyc < 500) begin
      if (rmode == 2 && cyc == 10) begin
        chk("bp_count_held", dut.count, 2);
        chk("bp_fetch_en_low", fetch_en_out, 0);
        chk("bp_no_overflow", overflow_out, 0);
      end
      tri_ready = pick(rmode, cyc);
      frame_start = ovr_pulse && (cyc == 1);
      if (fetch_en_out) begin
        tri_valid = 1'b1; tri_in = rtri();
        exp_q.push_back(tri_in);
        sent++;
        obj_done = done_with_last && (sent == n);
      end
      tick();
      tri_valid = 1'b0; obj_done = 1'b0; frame_start = 1'b0;
      cyc++;
    end
    if (sent < n) chk("fetch_budget", 0, 1);
    if (!done_with_last) begin obj_done = 1'b1; tick(); obj_done = 1'b0; end
    wait_idle(rmode);
    chk("delivered_count", got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) chk("delivered_order", got[i], exp_q[i]);
    chk("frame_done_pulses", fd_cnt, 1);
    if (ovr_pulse) chk("overrun_sticky", overrun_out, 1);
  endtask

  logic [TRI_W-1:0] t [6];

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_tri_valid", tri_valid_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_tri_out", tri_out, 0);
    chk("rst_fetch_en", fetch_en_out, 0);
    chk("rst_frame_done", frame_done_out, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Basic pass: three triangles, sink always ready, obj_done after the last one.
    run_pass(3, 0, 0, 0);
    chk("basic_idle", busy_out, 0);
    // Backpressure: sink stalled for 10 cycles while the source obeys fetch_en.
    run_pass(6, 2, 0, 0);
    // Overrun during FETCH, obj_done coincident with the last triangle.
    run_pass(5, 0, 1, 1);
    // Random passes.
    for (int k = 0; k < 8; k++) begin
      int n = $urandom_range(1, 9);
      run_pass(n, 1, $urandom_range(0, 1), (n >= 2) && ($urandom_range(0, 2) == 0));
    end

    // Directed fill, full-with-read, and forced overflow.
    for (int i = 0; i < 6; i++) t[i] = {12{32'hA000_0000 + i}};
    got.delete(); fd_cnt = 0;
    frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
    tri_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin tri_valid = 1'b1; tri_in = t[i]; tick(); end
    tri_valid = 1'b0;
    chk("full_count", dut.count, 4);
    chk("full_no_overflow", overflow_out, 0);
    tri_valid = 1'b1; tri_in = t[4]; tri_ready = 1'b1; tick();
    tri_valid = 1'b0; tri_ready = 1'b0;
    chk("full_rw_count", dut.count, 4);
    chk("full_rw_no_overflow", overflow_out, 0);
    chk("full_rw_head", tri_out, t[1]);
    tri_valid = 1'b1; tri_in = t[5]; tick(); tri_valid = 1'b0;
    chk("forced_overflow", overflow_out, 1);
    chk("forced_count", dut.count, 4);
    chk("forced_head", tri_out, t[1]);
    obj_done = 1'b1; tick(); obj_done = 1'b0;
    wait_idle(0);
    chk("forced_delivered", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("forced_order", got[i], t[i]);
    chk("forced_overflow_sticky", overflow_out, 1);
    chk("forced_frame_done", fd_cnt, 1);

    // Reset in DRAIN with two triangles held.
    frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
    tri_ready = 1'b0;
    tri_valid = 1'b1; tri_in = rtri(); tick();
    tri_in = rtri(); obj_done = 1'b1; tick();
    tri_valid = 1'b0; obj_done = 1'b0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("drain_count", dut.count, 2);
    chk("drain_overrun", overrun_out, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_tri_valid", tri_valid_out, 0);
    chk("mid_rst_busy", busy_out, 0);
    chk("mid_rst_overflow", overflow_out, 0);
    chk("mid_rst_overrun", overrun_out, 0);
    fd_cnt = 0;
    tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("post_rst_no_frame_done", fd_cnt, 0);
    chk("post_rst_busy", busy_out, 0);
    chk("post_rst_count", dut.count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
